bus_key_sequencer: RTL and testbench
====================================

// Module: bus_key_sequencer
// PURPOSE
//  Parametrised keyed bus sequencer, successor to the fixed 6-bit GAL key machine.
//  Watches qualified bus reads in a decoded window and requires a programmable address-offset
//  key sequence to unlock. Once unlocked, advances an address-mixed LFSR on every read and
//  returns DOUT_W parity bits of the current state on the data bus.
//  Adds lock/unlock mode, relock-by-write and zero-lockup recovery.
// PARAMETERS
//  STATE_W    6         LFSR state width (>= ADDR_W, >= 2)
//  ADDR_W     4         width of the address offset bits compared and mixed (BA7..BA4 today)
//  DOUT_W     2         number of returned data bits
//  UNLOCK_LEN 4         key sequence length (>= 1)
//  KEYS       16'h9A52  packed UNLOCK_LEN*ADDR_W key offsets, entry 0 in LSBs (2,5,A,9)
//  SEED       6'h2A     reset/relock/reseed state (must be nonzero)
//  TAPS       6'h21     LFSR feedback mask
//  MASKS      12'h8E5   packed DOUT_W*STATE_W parity masks, entry 0 in LSBs (0x25, 0x23)
//  RELOCK_OFS 4'hF      write offset that relocks
// PORTS
//  clk       in   1        system clock, all state on rising edge
//  rst       in   1        synchronous reset, active-high
//  sel_n     in   1        chip select, active-low (SSER)
//  win       in   1        decoded window hit (~BA13 & BA12)
//  rd        in   1        1 = read, 0 = write (BR_W)
//  strobe    in   1        one-cycle access-valid pulse
//  addr      in   ADDR_W   address offset bits
//  dout      out  DOUT_W   returned data bits (0 when dout_oe = 0)
//  dout_oe   out  1        drive enable for dout (board tristate is external)
//  unlocked  out  1        1 = UNLOCKED mode
//  state     out  STATE_W  current LFSR state (debug)
// BEHAVIOUR
//  - acc = strobe & ~sel_n & win. rd_acc = acc & rd. wr_acc = acc & ~rd.
//    With no acc, all registers hold.
//  - Reset: state = SEED, step = 0, mode = LOCKED.
//    Hence unlocked = 0, dout_oe = 0, dout = 0. rst has priority over any access.
//  - Mode LOCKED, rd_acc (dout_oe stays 0):
//    - addr == KEYS[step]: step + 1; on the last entry, go to UNLOCKED with step = 0.
//    - mismatch: step = (addr == KEYS[0]) ? 1 : 0.
//    - state holds SEED.
//  - Mode UNLOCKED, rd_acc:
//    - dout_oe = 1 combinationally in the same cycle.
//    - dout[i] = ^(state & MASKS[i]), taken from the pre-update state (zero latency).
//    - At the clock edge: nxt = {state[STATE_W-2:0], ^(state & TAPS)} ^ zero-extended addr.
//    - state = (nxt == 0) ? SEED : nxt (zero-lockup reseed).
//  - wr_acc with addr == RELOCK_OFS, any mode: state = SEED, step = 0, mode = LOCKED next cycle.
//  - Any other wr_acc is ignored. Writes never assert dout_oe.
//  - dout_oe is never registered; it deasserts the cycle strobe drops.
//  - UNLOCK_LEN = 1: a single matching read unlocks.
// TESTING
//  - Reset: assert rst 2 cycles with strobe high -> state=0x2A, unlocked=0, dout_oe=0, dout=0.
//  - Unlock: reads at ofs 2,5,A,9 -> unlocked=1 after the 4th edge.
//    dout_oe=0 on all 4; state remains 0x2A.
//  - Key restart: reads 2,5,2,5,A,9 -> unlocked only after the 6th.
//    Reads 2,5,7 -> step=0, unlocked=0.
//  - Data path, unlocked from SEED: read ofs 0 -> dout=2'b01, state becomes 0x15.
//    Next read ofs 0 -> dout=2'b10.
//  - Zero lockup, unlocked from 0x2A: reads 5,0,0,3 -> states 0x10, 0x20, 0x01, then 0x2A (reseed).
//  - Relock and qualifiers: write ofs F while unlocked -> unlocked=0, state=0x2A.
//    Read with sel_n=1, win=0 or strobe=0 -> no change, dout_oe=0.
//    Write ofs 3 -> ignored.

Source files
------------

// File: rtl/bus_key_sequencer.sv
// bus_key_sequencer: keyed bus sequencer.
// Qualified reads in the decoded window must match a programmed offset key
// sequence to unlock. Once unlocked, every read returns parity bits of an
// address-mixed LFSR state and then advances it. A write to the relock
// offset returns the block to LOCKED with the seed state.
module bus_key_sequencer #(
    parameter int unsigned STATE_W    = 6,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DOUT_W     = 2,
    parameter int unsigned UNLOCK_LEN = 4,
    parameter logic [UNLOCK_LEN*ADDR_W-1:0] KEYS       = 16'h9A52,
    parameter logic [STATE_W-1:0]           SEED       = 6'h2A,
    parameter logic [STATE_W-1:0]           TAPS       = 6'h21,
    parameter logic [DOUT_W*STATE_W-1:0]    MASKS      = 12'h8E5,
    parameter logic [ADDR_W-1:0]            RELOCK_OFS = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_n,
    input  logic               win,
    input  logic               rd,
    input  logic               strobe,
    input  logic [ADDR_W-1:0]  addr,
    output logic [DOUT_W-1:0]  dout,
    output logic               dout_oe,
    output logic               unlocked,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned STEP_W = (UNLOCK_LEN > 1) ? $clog2(UNLOCK_LEN) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(UNLOCK_LEN - 1);

    typedef enum logic {
        LOCKED   = 1'b0,
        UNLOCKED = 1'b1
    } mode_t;

    mode_t              mode_q, mode_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STATE_W-1:0] state_q, state_d;

    logic               acc;
    logic               rd_acc;
    logic               wr_acc;
    logic [ADDR_W-1:0]  key_cur;
    logic [ADDR_W-1:0]  key_first;
    logic               feedback;
    logic [STATE_W-1:0] lfsr_nxt;
    logic [DOUT_W-1:0]  parity;

    assign acc       = strobe & ~sel_n & win;
    assign rd_acc    = acc & rd;
    assign wr_acc    = acc & ~rd;
    assign key_first = KEYS[ADDR_W-1:0];

    // Select the key entry the current step expects.
    always_comb begin
        key_cur = '0;
        for (int unsigned i = 0; i < UNLOCK_LEN; i++) begin
            if (step_q == STEP_W'(i)) begin
                key_cur = KEYS[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // LFSR successor mixed with the read offset.
    always_comb begin
        feedback = ^(state_q & TAPS);
        lfsr_nxt = {state_q[STATE_W-2:0], feedback} ^ STATE_W'(addr);
    end

    // Parity taps on the pre-update state, returned with zero latency.
    always_comb begin
        parity = '0;
        for (int unsigned i = 0; i < DOUT_W; i++) begin
            parity[i] = ^(state_q & MASKS[i*STATE_W +: STATE_W]);
        end
    end

    // Next-state decision for mode, key step and LFSR state.
    always_comb begin
        mode_d  = mode_q;
        step_d  = step_q;
        state_d = state_q;
        if (wr_acc && (addr == RELOCK_OFS)) begin
            mode_d  = LOCKED;
            step_d  = '0;
            state_d = SEED;
        end else if (rd_acc) begin
            if (mode_q == LOCKED) begin
                if (addr == key_cur) begin
                    if (step_q == LAST_STEP) begin
                        mode_d = UNLOCKED;
                        step_d = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    // A mismatching read may itself be the start of a new attempt.
                    step_d = (addr == key_first) ? STEP_W'(1) : '0;
                end
            end else begin
                // An all-zero LFSR would stick forever, so reseed instead.
                state_d = (lfsr_nxt == '0) ? SEED : lfsr_nxt;
            end
        end
    end

    // State registers with synchronous reset taking priority over any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= LOCKED;
            step_q  <= '0;
            state_q <= SEED;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            state_q <= state_d;
        end
    end

    // Drive enable follows the live access, never registered.
    always_comb begin
        dout_oe = rd_acc & (mode_q == UNLOCKED);
        dout    = dout_oe ? parity : '0;
    end

    assign unlocked = (mode_q == UNLOCKED);
    assign state    = state_q;

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Self-checking bench for bus_key_sequencer with default parameters.
module tb_bus_key_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_n;
    logic       win;
    logic       rd;
    logic       strobe;
    logic [3:0] addr;
    logic [1:0] dout;
    logic       dout_oe;
    logic       unlocked;
    logic [5:0] state;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       oe;
        logic [1:0] dout;
        logic       unl;
        logic [5:0] st;
        string      tag;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic       m_unl;
    int         m_step;
    logic [5:0] m_st;
    logic [3:0] keys [4];

    logic [1:0] last_dout;

    bus_key_sequencer #(
        .STATE_W    (6),
        .ADDR_W     (4),
        .DOUT_W     (2),
        .UNLOCK_LEN (4),
        .KEYS       (16'h9A52),
        .SEED       (6'h2A),
        .TAPS       (6'h21),
        .MASKS      (12'h8E5),
        .RELOCK_OFS (4'hF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_n    (sel_n),
        .win      (win),
        .rd       (rd),
        .strobe   (strobe),
        .addr     (addr),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .unlocked (unlocked),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of bus activity (entered and left at posedge+1),
    // pushing the model's expectation and checking it as the DUT responds.
    task automatic access(input string tag, input logic s_n, input logic w,
                          input logic r, input logic stb, input logic [3:0] a);
        exp_t e;
        exp_t got_e;
        logic acc;
        logic [5:0] nxt;
        sel_n = s_n; win = w; rd = r; strobe = stb; addr = a;
        acc    = stb & ~s_n & w;
        e.tag  = tag;
        e.oe   = acc & r & m_unl;
        e.dout = e.oe ? {^(m_st & 6'h23), ^(m_st & 6'h25)} : 2'b00;
        if (acc && r) begin
            if (!m_unl) begin
                if (a == keys[m_step]) begin
                    if (m_step == 3) begin m_unl = 1'b1; m_step = 0; end
                    else m_step = m_step + 1;
                end else begin
                    m_step = (a == keys[0]) ? 1 : 0;
                end
            end else begin
                nxt  = {m_st[4:0], m_st[5] ^ m_st[0]} ^ {2'b00, a};
                m_st = (nxt == 6'h00) ? 6'h2A : nxt;
            end
        end else if (acc && !r && a == 4'hF) begin
            m_unl = 1'b0; m_step = 0; m_st = 6'h2A;
        end
        e.unl = m_unl;
        e.st  = m_st;
        sb.push_back(e);
        @(negedge clk);
        got_e = sb.pop_front();
        last_dout = dout;
        chk({got_e.tag, ".oe"},   {7'd0, dout_oe}, {7'd0, got_e.oe});
        chk({got_e.tag, ".dout"}, {6'd0, dout},    {6'd0, got_e.dout});
        @(posedge clk);
        #1;
        chk({got_e.tag, ".unl"},  {7'd0, unlocked}, {7'd0, got_e.unl});
        chk({got_e.tag, ".st"},   {2'd0, state},    {2'd0, got_e.st});
    endtask

    task automatic rd_ofs(input string tag, input logic [3:0] a);
        access(tag, 1'b0, 1'b1, 1'b1, 1'b1, a);
    endtask

    task automatic wr_ofs(input string tag, input logic [3:0] a);
        access(tag, 1'b0, 1'b1, 1'b0, 1'b1, a);
    endtask

    initial begin
        keys[0] = 4'h2; keys[1] = 4'h5; keys[2] = 4'hA; keys[3] = 4'h9;
        m_unl = 1'b0; m_step = 0; m_st = 6'h2A;

        // Reset held two cycles while a qualified read is presented
        rst = 1'b1; sel_n = 1'b0; win = 1'b1; rd = 1'b1; strobe = 1'b1; addr = 4'h2;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.state", {2'd0, state}, 8'h2A);
        chk("rst.unl",   {7'd0, unlocked}, 8'h00);
        chk("rst.oe",    {7'd0, dout_oe}, 8'h00);
        chk("rst.dout",  {6'd0, dout}, 8'h00);
        rst = 1'b0; strobe = 1'b0;
        @(posedge clk);
        #1;

        // Unlock with 2,5,A,9
        rd_ofs("unl0", 4'h2);
        rd_ofs("unl1", 4'h5);
        rd_ofs("unl2", 4'hA);
        chk("unl.not_yet", {7'd0, unlocked}, 8'h00);
        rd_ofs("unl3", 4'h9);
        chk("unl.done", {7'd0, unlocked}, 8'h01);
        chk("unl.seed", {2'd0, state}, 8'h2A);

        // Data path from seed
        rd_ofs("dp0", 4'h0);
        chk("dp0.dout", {6'd0, last_dout}, 8'h01);
        chk("dp0.state", {2'd0, state}, 8'h15);
        rd_ofs("dp1", 4'h0);
        chk("dp1.dout", {6'd0, last_dout}, 8'h02);

        // Relock by write
        wr_ofs("relock0", 4'hF);
        chk("relock0.unl", {7'd0, unlocked}, 8'h00);
        chk("relock0.st", {2'd0, state}, 8'h2A);

        // Key restart: 2,5,2,5,A,9
        rd_ofs("kr0", 4'h2);
        rd_ofs("kr1", 4'h5);
        rd_ofs("kr2", 4'h2);
        rd_ofs("kr3", 4'h5);
        rd_ofs("kr4", 4'hA);
        chk("kr.not_yet", {7'd0, unlocked}, 8'h00);
        rd_ofs("kr5", 4'h9);
        chk("kr.done", {7'd0, unlocked}, 8'h01);

        // Zero lockup from seed: 5,0,0,3
        rd_ofs("zl0", 4'h5);
        chk("zl0.st", {2'd0, state}, 8'h10);
        rd_ofs("zl1", 4'h0);
        chk("zl1.st", {2'd0, state}, 8'h20);
        rd_ofs("zl2", 4'h0);
        chk("zl2.st", {2'd0, state}, 8'h01);
        rd_ofs("zl3", 4'h3);
        chk("zl3.reseed", {2'd0, state}, 8'h2A);

        // Qualifiers while unlocked
        rd_ofs("q.adv", 4'h6);
        access("q.seln",   1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        access("q.win",    1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
        access("q.strobe", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        wr_ofs("q.wr3", 4'h3);
        chk("q.still_unl", {7'd0, unlocked}, 8'h01);
        rd_ofs("q.rd", 4'h1);
        wr_ofs("relock1", 4'hF);
        chk("relock1.unl", {7'd0, unlocked}, 8'h00);

        // 2,5,7 drops the step, so A,9 must not unlock
        rd_ofs("ks0", 4'h2);
        rd_ofs("ks1", 4'h5);
        rd_ofs("ks2", 4'h7);
        rd_ofs("ks3", 4'hA);
        rd_ofs("ks4", 4'h9);
        chk("ks.locked", {7'd0, unlocked}, 8'h00);

        // Relock write mid-key clears progress
        rd_ofs("mk0", 4'h2);
        rd_ofs("mk1", 4'h5);
        wr_ofs("mk.wrF", 4'hF);
        rd_ofs("mk2", 4'hA);
        rd_ofs("mk3", 4'h9);
        chk("mk.locked", {7'd0, unlocked}, 8'h00);

        // Clean unlock still works, then a few data reads
        rd_ofs("fin0", 4'h2);
        rd_ofs("fin1", 4'h5);
        rd_ofs("fin2", 4'hA);
        rd_ofs("fin3", 4'h9);
        chk("fin.unl", {7'd0, unlocked}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            rd_ofs("fin.rd", 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
